// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (icache/dcache) arbiter onto a single RAM port, dcache bursts of BURST_LEN words.
// Optional macro ARB_ROUND_ROBIN_EN: alternate priority between requesters instead of fixed dcache priority.
`default_nettype none

module mem_arbiter #(
  parameter int BURST_LEN = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DGRANT = 2'd1;
  localparam logic [1:0] IGRANT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          dreq;

  assign dreq = dREN | dWEN;

`ifdef ARB_ROUND_ROBIN_EN
  // prio_q=1 means dcache was served last, so icache wins a tie
  logic prio_q, prio_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
`ifdef ARB_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (dreq && !(iREN && prio_q)) begin
`else
        if (dreq) begin
`endif
          state_d = DGRANT;
          beat_d  = '0;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT: begin
        if (ram_ready) beat_d = beat_q + BW'(1);
        if (!dreq || (ram_ready && beat_q == LAST_BEAT)) begin
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          prio_d  = 1'b1;
`endif
        end
      end
      IGRANT: begin
        if (ram_ready || !iREN) begin
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          prio_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes follow the live request so a dropped request releases the RAM this cycle
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iload    = '0;
    dload    = '0;
    iwait    = iREN;
    dwait    = dreq;
    case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~ram_ready;
        dload    = ramload;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~ram_ready;
        iload   = ramload;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios then randomized traffic, checked each cycle against a grant-level model.
`default_nettype none

module tb_mem_arbiter;

  localparam int BURST_LEN = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;

  mem_arbiter #(.BURST_LEN(BURST_LEN)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: who owns the RAM (0 nobody, 1 dcache, 2 icache) and words moved in this dcache grant
  int owner = 0;
  int beats = 0;
`ifdef ARB_ROUND_ROBIN_EN
  int last_served = 2;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic        dreq;
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store;
    dreq    = dREN | dWEN;
    e_iwait = iREN;  e_dwait = dreq;
    e_ren   = 1'b0;  e_wen   = 1'b0;
    e_addr  = '0;    e_store = '0;
    e_iload = '0;    e_dload = '0;
    if (owner == 1) begin
      e_addr  = daddr;
      e_store = dstore;
      e_wen   = dWEN;
      e_ren   = dREN && !dWEN;
      e_dwait = !ram_ready;
      e_dload = ramload;
    end else if (owner == 2) begin
      e_addr  = iaddr;
      e_ren   = iREN;
      e_iwait = !ram_ready;
      e_iload = ramload;
    end
    chk("iwait",    {31'd0, iwait},  {31'd0, e_iwait});
    chk("dwait",    {31'd0, dwait},  {31'd0, e_dwait});
    chk("ramREN",   {31'd0, ramREN}, {31'd0, e_ren});
    chk("ramWEN",   {31'd0, ramWEN}, {31'd0, e_wen});
    chk("ramaddr",  ramaddr,  e_addr);
    chk("ramstore", ramstore, e_store);
    chk("iload",    iload,    e_iload);
    chk("dload",    dload,    e_dload);
  endtask

  task automatic model_reset();
    owner = 0;
    beats = 0;
`ifdef ARB_ROUND_ROBIN_EN
    last_served = 2;
`endif
  endtask

  task automatic model_step();
    logic dreq;
    dreq = dREN | dWEN;
    if (!nRST) begin
      model_reset();
      return;
    end
    case (owner)
      0: begin
        if (dreq && iREN) begin
`ifdef ARB_ROUND_ROBIN_EN
          owner = (last_served == 1) ? 2 : 1;
`else
          owner = 1;
`endif
        end else if (dreq) owner = 1;
        else if (iREN)     owner = 2;
        beats = 0;
      end
      1: begin
        if (ram_ready) beats++;
        if (!dreq || beats >= BURST_LEN) begin
          owner = 0;
`ifdef ARB_ROUND_ROBIN_EN
          last_served = 1;
`endif
        end
      end
      default: begin
        if (ram_ready || !iREN) begin
          owner = 0;
`ifdef ARB_ROUND_ROBIN_EN
          last_served = 2;
`endif
        end
      end
    endcase
  endtask

  // Inputs are set at the falling edge; outputs checked 1ns later, model advanced at the rising edge
  task automatic cycle();
    if (!nRST) model_reset();
    #1;
    check_outputs();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input logic rr);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds; ram_ready = rr;
    ramload = $urandom;
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    cycle();
    drive(1, 32'h44, 1, 1, 32'h88, 32'h1234, 1);
    cycle();
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Write wins when both dcache strobes are high
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 1, 1, 32'h40, 32'hDEADBEEF, c >= 2);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Two-beat read burst with ready on cycles 3 and 5
    for (int c = 1; c <= 7; c++) begin
      drive(0, 0, 1, 0, 32'h100, 0, (c == 3) || (c == 5));
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // Simultaneous icache read and dcache write
    for (int c = 0; c < 9; c++) begin
      drive(1, 32'h200, 0, 1, 32'h300, 32'hCAFE0000 + c, 1);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();

    // icache abandons its request before ready
    drive(1, 32'h500, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    drive(0, 32'h500, 0, 0, 0, 0, 0);
    cycle();
    cycle();

    // Reset during the first beat of a burst
    drive(0, 0, 1, 0, 32'h600, 0, 0);
    cycle();
    cycle();
    nRST = 1'b0;
    drive(0, 0, 1, 0, 32'h600, 0, 1);
    cycle();
    nRST = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();

    // Randomized traffic with sticky requests and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 3) == 0) dREN = ~dREN;
      if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
      iaddr     = $urandom;
      daddr     = $urandom;
      dstore    = $urandom;
      ramload   = $urandom;
      ram_ready = ($urandom_range(0, 2) != 0);
      nRST      = ($urandom_range(0, 199) != 0);
      cycle();
      nRST = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
